// File: rtl/adder_tree_acc_if.sv
// Beat input / packet result bundle for adder_tree_acc.
// The design drives the result side through the slave modport; the producer uses master.
interface adder_tree_acc_if #(
  parameter int N_IN  = 16,
  parameter int IN_W  = 16,
  parameter int ACC_W = 40
);
  logic                    clear;
  logic                    in_valid;
  logic                    in_last;
  logic [N_IN*IN_W-1:0]    in_data;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_sum;
  logic                    out_ovf;

  modport master (
    output clear, in_valid, in_last, in_data,
    input  out_valid, out_sum, out_ovf
  );

  modport slave (
    input  clear, in_valid, in_last, in_data,
    output out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree (log2(N_IN) registered levels) followed by a packet accumulator.
// Optional macro ADDER_TREE_ACC_SAT_EN enables saturating accumulation and the out_ovf flag.
module adder_tree_acc #(
  parameter int N_IN  = 16,
  parameter int IN_W  = 16,
  parameter int ACC_W = 40
) (
  input logic          clk,
  input logic          reset,
  adder_tree_acc_if.slave bus
);
  localparam int L  = $clog2(N_IN);
  localparam int TW = IN_W + L;

  // Level j holds N_IN>>j partial sums of IN_W+j bits; level 0 is the raw input.
  for (genvar j = 0; j <= L; j++) begin : lvl
    localparam int W   = IN_W + j;
    localparam int CNT = N_IN >> j;
    logic signed [W-1:0] sum [CNT];
    logic                vld;
    logic                lst;

    if (j == 0) begin : g_in
      for (genvar k = 0; k < CNT; k++) begin : g_op
        assign sum[k] = bus.in_data[k*IN_W +: IN_W];
      end
      assign vld = bus.in_valid & ~bus.clear;
      assign lst = bus.in_last;
    end else begin : g_add
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < CNT; k++) sum[k] <= '0;
          vld <= 1'b0;
          lst <= 1'b0;
        end else if (bus.clear) begin
          vld <= 1'b0;
          lst <= 1'b0;
        end else begin
          vld <= lvl[j-1].vld;
          lst <= lvl[j-1].lst;
          for (int k = 0; k < CNT; k++)
            sum[k] <= {lvl[j-1].sum[2*k][W-2], lvl[j-1].sum[2*k]} +
                      {lvl[j-1].sum[2*k+1][W-2], lvl[j-1].sum[2*k+1]};
        end
      end
    end
  end

  logic signed [TW-1:0]    tree_sum;
  logic signed [ACC_W-1:0] tree_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_next;
  logic                    tree_vld;
  logic                    tree_lst;
  logic                    in_pkt;

  assign tree_sum = lvl[L].sum[0];
  assign tree_vld = lvl[L].vld;
  assign tree_lst = lvl[L].lst;
  assign tree_ext = ACC_W'(tree_sum);
  // in_pkt low means the next valid beat starts a fresh packet.
  assign acc_base = in_pkt ? acc : '0;

`ifdef ADDER_TREE_ACC_SAT_EN
  logic signed [ACC_W:0] wide;
  logic                  clip;
  logic                  ovf_seen;

  always_comb begin
    wide     = {acc_base[ACC_W-1], acc_base} + {tree_ext[ACC_W-1], tree_ext};
    clip     = wide[ACC_W] ^ wide[ACC_W-1];
    acc_next = wide[ACC_W-1:0];
    if (clip)
      acc_next = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

  // out_ovf reports the finished packet and drops when the next packet begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_seen    <= 1'b0;
      bus.out_ovf <= 1'b0;
    end else if (bus.clear) begin
      ovf_seen    <= 1'b0;
      bus.out_ovf <= 1'b0;
    end else if (tree_vld) begin
      if (tree_lst) begin
        bus.out_ovf <= (in_pkt & ovf_seen) | clip;
        ovf_seen    <= 1'b0;
      end else begin
        ovf_seen <= (in_pkt & ovf_seen) | clip;
        if (!in_pkt) bus.out_ovf <= 1'b0;
      end
    end
  end
`else
  assign acc_next    = acc_base + tree_ext;
  assign bus.out_ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc           <= '0;
      in_pkt        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
    end else if (bus.clear) begin
      acc           <= '0;
      in_pkt        <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (tree_vld) begin
        acc    <= acc_next;
        in_pkt <= ~tree_lst;
        if (tree_lst) begin
          bus.out_valid <= 1'b1;
          bus.out_sum   <= acc_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_tree_acc.sv
// Self-checking bench for adder_tree_acc: vector table, directed corner sequences and a
// randomized phase scored against a packet-level arithmetic model.
module tb_adder_tree_acc;
  localparam int N_IN    = 16;
  localparam int IN_W    = 16;
  localparam int ACC_W   = 40;
  localparam int ACC_W_S = 20;
  localparam int DW      = N_IN * IN_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adder_tree_acc_if #(.N_IN(N_IN), .IN_W(IN_W), .ACC_W(ACC_W))   bus0 ();
  adder_tree_acc_if #(.N_IN(N_IN), .IN_W(IN_W), .ACC_W(ACC_W_S)) bus1 ();

  adder_tree_acc #(.N_IN(N_IN), .IN_W(IN_W), .ACC_W(ACC_W)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  adder_tree_acc #(.N_IN(N_IN), .IN_W(IN_W), .ACC_W(ACC_W_S)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [IN_W-1:0] val;
    int                     beats;
    longint                 exp_sum;
  } vec_t;

  typedef struct {
    longint sum;
    bit     ovf;
    int     due;
  } res_t;

  vec_t vecs[7];
  res_t exp_q[$];

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [IN_W-1:0] v);
    return {N_IN{v}};
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < N_IN; k++) d[k*IN_W +: IN_W] = IN_W'($urandom);
    return d;
  endfunction

  function automatic longint beat_sum(input logic [DW-1:0] d);
    longint s = 0;
    for (int k = 0; k < N_IN; k++) s += longint'($signed(d[k*IN_W +: IN_W]));
    return s;
  endfunction

  // One accumulate of width w: clipped to range when saturating, else modulo 2^w.
  function automatic longint model_add(input longint a, input longint b, input int w,
                                       output bit clipped);
    longint s    = a + b;
    longint maxv = (longint'(1) << (w - 1)) - 1;
    longint minv = -maxv - 1;
    clipped = 1'b0;
`ifdef ADDER_TREE_ACC_SAT_EN
    if (s > maxv) begin s = maxv; clipped = 1'b1; end
    else if (s < minv) begin s = minv; clipped = 1'b1; end
`else
    s = s & ((longint'(1) << w) - 1);
    if (s > maxv) s = s - (longint'(1) << w);
`endif
    return s;
  endfunction

  task automatic set_idle();
    bus0.in_valid = 1'b0;
    bus0.in_last  = 1'b0;
    bus0.clear    = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.in_last  = 1'b0;
    bus1.clear    = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [DW-1:0] data, input bit valid, input bit last,
                                input bit clr);
    bus0.in_data  = data;
    bus0.in_valid = valid;
    bus0.in_last  = last;
    bus0.clear    = clr;
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the capture edge of the last beat until out_valid shows.
  task automatic wait_result(output int cycles);
    cycles = 1;
    set_idle();
    while (bus0.out_valid !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int     cyc;
    int     hits;
    int     edge_no;
    bit     valid, last, clr, clipped, m_in_pkt, m_ovf;
    longint m_acc, last_sum, bs;
    logic [DW-1:0] data;

    vecs[0] = '{16'sd1,     1, 16};
    vecs[1] = '{16'sh8000,  4, -2097152};
    vecs[2] = '{16'sd2,     3, 96};
    vecs[3] = '{16'sd3,     1, 48};
    vecs[4] = '{-16'sd1,    2, -32};
    vecs[5] = '{16'sd32767, 1, 524272};
    vecs[6] = '{-16'sd5,    3, -240};

    reset = 1'b1;
    set_idle();
    bus0.in_data = '0;
    bus1.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset out_valid", longint'(bus0.out_valid), 0);
    check_output("reset out_sum",   longint'(bus0.out_sum), 0);
    check_output("reset out_ovf",   longint'(bus0.out_ovf), 0);
    check_output("reset out_sum s", longint'(bus1.out_sum), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < vecs[i].beats; b++)
        apply_stimulus(fill(vecs[i].val), 1'b1, b == vecs[i].beats - 1, 1'b0);
      wait_result(cyc);
      check_output($sformatf("vec%0d latency", i), cyc, 5);
      check_output($sformatf("vec%0d sum", i), longint'(bus0.out_sum), vecs[i].exp_sum);
      check_output($sformatf("vec%0d ovf", i), longint'(bus0.out_ovf), 0);
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d pulse end", i), longint'(bus0.out_valid), 0);
      check_output($sformatf("vec%0d sum hold", i), longint'(bus0.out_sum), vecs[i].exp_sum);
    end

    // Back-to-back packets with bubbles carrying junk data.
    apply_stimulus(fill(16'sd2), 1'b1, 1'b0, 1'b0);
    apply_stimulus(rand_data(),  1'b0, 1'b1, 1'b0);
    apply_stimulus(fill(16'sd2), 1'b1, 1'b0, 1'b0);
    apply_stimulus(rand_data(),  1'b0, 1'b0, 1'b0);
    apply_stimulus(fill(16'sd2), 1'b1, 1'b1, 1'b0);
    apply_stimulus(fill(16'sd1), 1'b1, 1'b1, 1'b0);
    wait_result(cyc);
    check_output("b2b first latency", cyc, 4);
    check_output("b2b first sum", longint'(bus0.out_sum), 96);
    @(posedge clk);
    #1;
    check_output("b2b second valid", longint'(bus0.out_valid), 1);
    check_output("b2b second sum", longint'(bus0.out_sum), 16);

    // Clear on beat 2 aborts the packet; the clear-cycle beat is dropped.
    apply_stimulus(fill(16'sd5), 1'b1, 1'b0, 1'b0);
    apply_stimulus(fill(16'sd5), 1'b1, 1'b0, 1'b1);
    check_output("clear out_valid", longint'(bus0.out_valid), 0);
    check_output("clear sum hold", longint'(bus0.out_sum), 16);
    apply_stimulus(fill(16'sd3), 1'b1, 1'b1, 1'b0);
    wait_result(cyc);
    check_output("after clear latency", cyc, 5);
    check_output("after clear sum", longint'(bus0.out_sum), 48);

    // Narrow accumulator: overflow behaviour depends on the saturation option.
    for (int b = 0; b < 4; b++) begin
      bus1.in_data  = fill(16'sd32767);
      bus1.in_valid = 1'b1;
      bus1.in_last  = (b == 3);
      @(posedge clk);
      #1;
    end
    set_idle();
    cyc = 1;
    while (bus1.out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_output("narrow latency", cyc, 5);
`ifdef ADDER_TREE_ACC_SAT_EN
    check_output("narrow sum", longint'(bus1.out_sum), 524287);
    check_output("narrow ovf", longint'(bus1.out_ovf), 1);
`else
    check_output("narrow sum", longint'(bus1.out_sum), -64);
    check_output("narrow ovf", longint'(bus1.out_ovf), 0);
`endif
    bus1.in_data  = fill(16'sd1);
    bus1.in_valid = 1'b1;
    bus1.in_last  = 1'b1;
    @(posedge clk);
    #1;
    set_idle();
    repeat (4) @(posedge clk);
    #1;
    check_output("narrow next valid", longint'(bus1.out_valid), 1);
    check_output("narrow next sum", longint'(bus1.out_sum), 16);
    check_output("narrow next ovf", longint'(bus1.out_ovf), 0);

    // Asynchronous reset mid-packet.
    apply_stimulus(fill(16'sd7), 1'b1, 1'b0, 1'b0);
    apply_stimulus(fill(16'sd7), 1'b1, 1'b0, 1'b0);
    set_idle();
    #2 reset = 1'b1;
    #1;
    check_output("async reset out_valid", longint'(bus0.out_valid), 0);
    check_output("async reset out_sum", longint'(bus0.out_sum), 0);
    check_output("async reset out_sum s", longint'(bus1.out_sum), 0);
    #2 reset = 1'b0;
    hits = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus0.out_valid === 1'b1) hits++;
    end
    check_output("post reset no output", hits, 0);
    apply_stimulus(fill(16'sd7), 1'b1, 1'b1, 1'b0);
    wait_result(cyc);
    check_output("post reset latency", cyc, 5);
    check_output("post reset sum", longint'(bus0.out_sum), 112);
    @(posedge clk);
    #1;

    // Randomized traffic against the packet model.
    edge_no  = 0;
    m_in_pkt = 1'b0;
    m_acc    = 0;
    m_ovf    = 1'b0;
    last_sum = 112;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      valid = ($urandom_range(0, 3) != 0);
      last  = ($urandom_range(0, 3) == 0);
      clr   = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 7))
        0:       data = fill(16'sh8000);
        1:       data = fill(16'sd32767);
        default: data = rand_data();
      endcase
      if (clr) begin
        exp_q.delete();
        m_in_pkt = 1'b0;
        m_ovf    = 1'b0;
      end else if (valid) begin
        bs    = beat_sum(data);
        m_acc = model_add(m_in_pkt ? m_acc : 0, bs, ACC_W, clipped);
        m_ovf = (m_in_pkt & m_ovf) | clipped;
        if (last) exp_q.push_back('{m_acc, m_ovf, edge_no + 5});
        m_in_pkt = !last;
      end
      apply_stimulus(data, valid, last, clr);
      edge_no++;
      if (exp_q.size() > 0 && exp_q[0].due == edge_no) begin
        check_output("rand out_valid", longint'(bus0.out_valid), 1);
        check_output("rand out_sum", longint'(bus0.out_sum), exp_q[0].sum);
        check_output("rand out_ovf", longint'(bus0.out_ovf), longint'(exp_q[0].ovf));
        last_sum = exp_q[0].sum;
        void'(exp_q.pop_front());
      end else begin
        check_output("rand idle out_valid", longint'(bus0.out_valid), 0);
        check_output("rand out_sum hold", longint'(bus0.out_sum), last_sum);
      end
    end

    set_idle();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      edge_no++;
      if (exp_q.size() > 0 && exp_q[0].due == edge_no) begin
        check_output("drain out_valid", longint'(bus0.out_valid), 1);
        check_output("drain out_sum", longint'(bus0.out_sum), exp_q[0].sum);
        void'(exp_q.pop_front());
      end else begin
        check_output("drain idle out_valid", longint'(bus0.out_valid), 0);
      end
    end
    check_output("drain queue empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
